// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared exception codes, flag positions and priority selector
package exc_ctrl_pkg;

  typedef enum logic [3:0] {
    EXC_NONE = 4'd0,
    EXC_INT  = 4'd1,
    EXC_IF   = 4'd2,
    EXC_ADEL = 4'd3,
    EXC_RI   = 4'd4,
    EXC_OV   = 4'd5,
    EXC_BP   = 4'd6,
    EXC_SYS  = 4'd7,
    EXC_ADES = 4'd8,
    EXC_ERET = 4'd9
  } exc_type_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } exc_state_e;

  localparam int FLAG_IF_ADEL = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_BP      = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_ADEL    = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [4:0]  CP0_REG_COMPARE    = 5'd11;

  // SYS deliberately outranks BP even though BP has the lower flag bit.
  function automatic exc_type_e exc_select(input logic int_req, input logic [7:0] flags);
    if (int_req)                 return EXC_INT;
    else if (flags[FLAG_IF_ADEL]) return EXC_IF;
    else if (flags[FLAG_RI])      return EXC_RI;
    else if (flags[FLAG_OV])      return EXC_OV;
    else if (flags[FLAG_SYS])     return EXC_SYS;
    else if (flags[FLAG_BP])      return EXC_BP;
    else if (flags[FLAG_ADEL])    return EXC_ADEL;
    else if (flags[FLAG_ADES])    return EXC_ADES;
    else if (flags[FLAG_ERET])    return EXC_ERET;
    else                          return EXC_NONE;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - CP0 commit outputs and IF redirect handshake
interface exc_ctrl_if;
  logic [3:0]  exc_type_o;
  logic        delayslot_o;
  logic [31:0] exc_pc_o;
  logic [31:0] badvaddr_o;
  logic [5:0]  hw_int_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (
    output exc_type_o, delayslot_o, exc_pc_o, badvaddr_o, hw_int_o,
    output flush_o, redirect_valid_o, redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  exc_type_o, delayslot_o, exc_pc_o, badvaddr_o, hw_int_o,
    input  flush_o, redirect_valid_o, redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/exc_int_sync.sv
// rtl/exc_int_sync.sv - external interrupt synchroniser and timer-interrupt latch
module exc_int_sync
  import exc_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic [31:0] count_i,
  input  logic [31:0] compare_i,
  input  logic        cp0_write_en_i,
  input  logic [4:0]  cp0_write_addr_i,
  output logic [5:0]  sync_int,
  output logic        timer_int
);

  logic [5:0] stage_q [SYNC_STAGES];
  logic       timer_set;
  logic       timer_clr;

  assign timer_set = (compare_i != 32'd0) && (count_i == compare_i);
  assign timer_clr = cp0_write_en_i && (cp0_write_addr_i == CP0_REG_COMPARE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      timer_int <= 1'b0;
    end else begin
      stage_q[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      // A COMPARE write acknowledges the timer even if the match is still live.
      if (timer_clr)      timer_int <= 1'b0;
      else if (timer_set) timer_int <= 1'b1;
    end
  end

  assign sync_int = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception prioritiser, CP0 commit driver and IF redirect FSM
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [7:0]  mem_exc_flags_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic [31:0] mem_data_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] count_i,
  input  logic [31:0] compare_i,
  input  logic        cp0_write_en_i,
  input  logic [4:0]  cp0_write_addr_i,
  exc_ctrl_if.master  bus
);

  exc_state_e  state_q, state_d;
  logic [31:0] redirect_pc_q;
  logic [5:0]  sync_int;
  logic        timer_int;
  logic [5:0]  hw_int;
  logic        int_req;
  logic        commit;
  exc_type_e   sel_type;

  exc_type_e   exc_type;
  logic        delayslot;
  logic [31:0] exc_pc;
  logic [31:0] badvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  exc_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clk              (clk),
    .rst              (rst),
    .int_i            (int_i),
    .count_i          (count_i),
    .compare_i        (compare_i),
    .cp0_write_en_i   (cp0_write_en_i),
    .cp0_write_addr_i (cp0_write_addr_i),
    .sync_int         (sync_int),
    .timer_int        (timer_int)
  );

  // Line 5 is owned by the timer, matching Cause.IP7.
  assign hw_int  = {timer_int, sync_int[4:0]};
  assign int_req = status_i[0] & ~status_i[1] & (|({hw_int, cause_i[9:8]} & status_i[15:8]));
  assign sel_type = exc_select(int_req, mem_exc_flags_i);
  assign commit  = (state_q == ST_IDLE) & mem_valid_i & ~mem_stall_i
                 & (int_req | (|mem_exc_flags_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (commit) redirect_pc_q <= (sel_type == EXC_ERET) ? epc_i : EXC_VECTOR;
    end
  end

  always_comb begin
    state_d        = state_q;
    exc_type       = EXC_NONE;
    delayslot      = 1'b0;
    exc_pc         = '0;
    badvaddr       = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d   = ST_REDIRECT;
          exc_type  = sel_type;
          delayslot = mem_delayslot_i;
          exc_pc    = mem_pc_i;
          flush     = 1'b1;
          if (sel_type == EXC_IF)
            badvaddr = mem_pc_i;
          else if (sel_type == EXC_ADEL || sel_type == EXC_ADES)
            badvaddr = mem_data_addr_i;
        end
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = redirect_pc_q;
        if (bus.redirect_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.exc_type_o       = exc_type;
  assign bus.delayslot_o      = delayslot;
  assign bus.exc_pc_o         = exc_pc;
  assign bus.badvaddr_o       = badvaddr;
  assign bus.hw_int_o         = hw_int;
  assign bus.flush_o          = flush;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        mem_valid_i, mem_stall_i, mem_delayslot_i;
  logic [7:0]  mem_exc_flags_i;
  logic [31:0] mem_pc_i, mem_data_addr_i;
  logic [31:0] status_i, cause_i, epc_i, count_i, compare_i;
  logic        cp0_write_en_i;
  logic [4:0]  cp0_write_addr_i;

  int n_tests = 0;
  int n_fail  = 0;

  exc_ctrl_if bus();

  exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .int_i            (int_i),
    .mem_valid_i      (mem_valid_i),
    .mem_stall_i      (mem_stall_i),
    .mem_exc_flags_i  (mem_exc_flags_i),
    .mem_pc_i         (mem_pc_i),
    .mem_delayslot_i  (mem_delayslot_i),
    .mem_data_addr_i  (mem_data_addr_i),
    .status_i         (status_i),
    .cause_i          (cause_i),
    .epc_i            (epc_i),
    .count_i          (count_i),
    .compare_i        (compare_i),
    .cp0_write_en_i   (cp0_write_en_i),
    .cp0_write_addr_i (cp0_write_addr_i),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Priority order as a table: flag bit index and exception code, highest first.
  function automatic logic [3:0] ref_type(input logic int_req, input logic [7:0] flags);
    int bit_order [8] = '{0, 1, 2, 4, 3, 5, 6, 7};
    int code_of   [8] = '{2, 4, 5, 7, 6, 3, 8, 9};
    if (int_req) return 4'd1;
    for (int k = 0; k < 8; k++)
      if (flags[bit_order[k]]) return 4'(code_of[k]);
    return 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    int_i = '0; mem_valid_i = 0; mem_stall_i = 0; mem_delayslot_i = 0;
    mem_exc_flags_i = '0; mem_pc_i = '0; mem_data_addr_i = '0;
    status_i = '0; cause_i = '0; epc_i = '0; count_i = '0; compare_i = '0;
    cp0_write_en_i = 0; cp0_write_addr_i = '0; bus.redirect_ready_i = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick(); settle();
    n_tests++;
    if ({bus.exc_type_o, bus.delayslot_o, bus.exc_pc_o, bus.badvaddr_o} !== 69'd0) begin
      n_fail++; $display("FAIL reset_commit got type=%0d ds=%0b pc=%h bva=%h exp all 0",
        bus.exc_type_o, bus.delayslot_o, bus.exc_pc_o, bus.badvaddr_o);
    end
    n_tests++;
    if ({bus.hw_int_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o} !== 40'd0) begin
      n_fail++; $display("FAIL reset_redirect got hw=%b fl=%b rv=%b rpc=%h exp all 0",
        bus.hw_int_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o);
    end
    rst = 0;
  endtask

  task automatic test_ov();
    tick();
    mem_valid_i = 1; mem_exc_flags_i = 8'h04; mem_pc_i = 32'h8000_0100; bus.redirect_ready_i = 1;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.exc_pc_o} !== {4'd5, 1'b1, 1'b0, 32'h8000_0100}) begin
      n_fail++; $display("FAIL ov_commit got type=%0d fl=%b rv=%b pc=%h exp 5 1 0 80000100",
        bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.exc_pc_o);
    end
    tick();
    mem_valid_i = 0; mem_exc_flags_i = '0;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o} !== {4'd0, 1'b1, 1'b1, VEC}) begin
      n_fail++; $display("FAIL ov_redirect got type=%0d fl=%b rv=%b rpc=%h exp 0 1 1 %h",
        bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, VEC);
    end
    tick(); settle();
    n_tests++;
    if ({bus.flush_o, bus.redirect_valid_o} !== 2'b00) begin
      n_fail++; $display("FAIL ov_idle got fl=%b rv=%b exp 0 0", bus.flush_o, bus.redirect_valid_o);
    end
  endtask

  task automatic test_prio();
    tick();
    mem_valid_i = 1; mem_exc_flags_i = 8'h12; mem_delayslot_i = 1; mem_pc_i = 32'h8000_0444;
    mem_data_addr_i = 32'h0000_5555; bus.redirect_ready_i = 1;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.delayslot_o, bus.exc_pc_o, bus.badvaddr_o} !== {4'd4, 1'b1, 32'h8000_0444, 32'd0}) begin
      n_fail++; $display("FAIL prio_ri_sys got type=%0d ds=%b pc=%h bva=%h exp 4 1 80000444 0",
        bus.exc_type_o, bus.delayslot_o, bus.exc_pc_o, bus.badvaddr_o);
    end
    tick();
    mem_valid_i = 0; mem_exc_flags_i = '0; mem_delayslot_i = 0;
    tick();
    mem_valid_i = 1; mem_exc_flags_i = 8'h40; mem_data_addr_i = 32'h0000_1003; mem_pc_i = 32'h8000_0448;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.delayslot_o, bus.badvaddr_o} !== {4'd8, 1'b0, 32'h0000_1003}) begin
      n_fail++; $display("FAIL prio_ades got type=%0d ds=%b bva=%h exp 8 0 00001003",
        bus.exc_type_o, bus.delayslot_o, bus.badvaddr_o);
    end
    tick();
    mem_valid_i = 0; mem_exc_flags_i = '0;
    tick();
  endtask

  task automatic test_eret();
    mem_valid_i = 1; mem_exc_flags_i = 8'h80; epc_i = 32'h8000_2000; mem_pc_i = 32'h8000_0500;
    bus.redirect_ready_i = 0;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.badvaddr_o} !== {4'd9, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL eret_commit got type=%0d fl=%b bva=%h exp 9 1 0",
        bus.exc_type_o, bus.flush_o, bus.badvaddr_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      n_tests++;
      if ({bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o} !== {4'd0, 1'b1, 1'b1, 32'h8000_2000}) begin
        n_fail++; $display("FAIL eret_hold%0d got type=%0d fl=%b rv=%b rpc=%h exp 0 1 1 80002000",
          i, bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o);
      end
    end
    tick();
    bus.redirect_ready_i = 1; mem_valid_i = 0; mem_exc_flags_i = '0;
    settle();
    n_tests++;
    if ({bus.redirect_valid_o, bus.redirect_pc_o} !== {1'b1, 32'h8000_2000}) begin
      n_fail++; $display("FAIL eret_last got rv=%b rpc=%h exp 1 80002000", bus.redirect_valid_o, bus.redirect_pc_o);
    end
    tick(); settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.redirect_valid_o} !== 6'd0) begin
      n_fail++; $display("FAIL eret_release got type=%0d fl=%b rv=%b exp 0 0 0",
        bus.exc_type_o, bus.flush_o, bus.redirect_valid_o);
    end
  endtask

  task automatic test_int();
    status_i = 32'h0000_1003;
    tick();
    int_i = 6'b000100;
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL int_lat1 got hw2=%b exp 0", bus.hw_int_o[2]);
    end
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o !== 6'b000100) begin
      n_fail++; $display("FAIL int_lat2 got hw=%b exp 000100", bus.hw_int_o);
    end
    mem_valid_i = 1; mem_pc_i = 32'h8000_0700;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o} !== 5'd0) begin
      n_fail++; $display("FAIL int_exl got type=%0d fl=%b exp 0 0", bus.exc_type_o, bus.flush_o);
    end
    tick();
    status_i = 32'h0000_1001;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.exc_pc_o} !== {4'd1, 1'b1, 32'h8000_0700}) begin
      n_fail++; $display("FAIL int_commit got type=%0d fl=%b pc=%h exp 1 1 80000700",
        bus.exc_type_o, bus.flush_o, bus.exc_pc_o);
    end
    tick();
    mem_valid_i = 0; int_i = '0; bus.redirect_ready_i = 1;
    tick(); tick(); tick();
    status_i = '0;
  endtask

  task automatic test_timer();
    compare_i = 32'd5; count_i = 32'd3;
    tick();
    count_i = 32'd4;
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b0) begin
      n_fail++; $display("FAIL timer_pre got %b exp 0", bus.hw_int_o[5]);
    end
    count_i = 32'd5;
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b1) begin
      n_fail++; $display("FAIL timer_set got %b exp 1", bus.hw_int_o[5]);
    end
    cp0_write_en_i = 1; cp0_write_addr_i = 5'd11;
    tick();
    cp0_write_en_i = 0; count_i = 32'd6;
    settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b0) begin
      n_fail++; $display("FAIL timer_clr_wins got %b exp 0", bus.hw_int_o[5]);
    end
    tick(); count_i = 32'd5;
    tick(); count_i = 32'd7;
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b1) begin
      n_fail++; $display("FAIL timer_latched got %b exp 1", bus.hw_int_o[5]);
    end
    cp0_write_en_i = 1; cp0_write_addr_i = 5'd10;
    tick(); settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b1) begin
      n_fail++; $display("FAIL timer_other_reg got %b exp 1", bus.hw_int_o[5]);
    end
    cp0_write_addr_i = 5'd11;
    tick();
    cp0_write_en_i = 0;
    settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b0) begin
      n_fail++; $display("FAIL timer_later_clr got %b exp 0", bus.hw_int_o[5]);
    end
    compare_i = '0; count_i = '0;
    tick(); tick(); settle();
    n_tests++;
    if (bus.hw_int_o[5] !== 1'b0) begin
      n_fail++; $display("FAIL timer_zero_compare got %b exp 0", bus.hw_int_o[5]);
    end
  endtask

  task automatic test_stall_reset();
    mem_valid_i = 1; mem_stall_i = 1; mem_exc_flags_i = 8'h20; mem_pc_i = 32'h8000_0600;
    mem_data_addr_i = 32'h0000_2001; bus.redirect_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if ({bus.exc_type_o, bus.flush_o} !== 5'd0) begin
        n_fail++; $display("FAIL stall_hold%0d got type=%0d fl=%b exp 0 0", i, bus.exc_type_o, bus.flush_o);
      end
      tick();
    end
    mem_stall_i = 0;
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.badvaddr_o} !== {4'd3, 1'b1, 32'h0000_2001}) begin
      n_fail++; $display("FAIL stall_commit got type=%0d fl=%b bva=%h exp 3 1 00002001",
        bus.exc_type_o, bus.flush_o, bus.badvaddr_o);
    end
    tick();
    settle();
    n_tests++;
    if ({bus.exc_type_o, bus.redirect_valid_o, bus.redirect_pc_o} !== {4'd0, 1'b1, VEC}) begin
      n_fail++; $display("FAIL stall_single got type=%0d rv=%b rpc=%h exp 0 1 %h",
        bus.exc_type_o, bus.redirect_valid_o, bus.redirect_pc_o, VEC);
    end
    mem_valid_i = 0; mem_exc_flags_i = '0;
    rst = 1;
    tick(); settle();
    n_tests++;
    if ({bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, bus.exc_pc_o, bus.badvaddr_o} !== 103'd0) begin
      n_fail++; $display("FAIL reset_mid_redirect got type=%0d fl=%b rv=%b rpc=%h exp all 0",
        bus.exc_type_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o);
    end
    rst = 0;
    tick(); settle();
    n_tests++;
    if (bus.redirect_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_dropped got rv=%b exp 0", bus.redirect_valid_o);
    end
  endtask

  // Only software interrupts are exercised here so hw_int stays zero throughout.
  task automatic test_random();
    logic        m_redir = 0;
    logic [31:0] m_rpc = '0;
    logic        m_int;
    logic [3:0]  e_type;
    logic        e_commit;
    logic [102:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      tick();
      mem_valid_i     = 1'($urandom_range(0, 1));
      mem_stall_i     = ($urandom_range(0, 3) == 0);
      mem_delayslot_i = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       mem_exc_flags_i = 8'($urandom);
        1:       mem_exc_flags_i = 8'(1 << $urandom_range(0, 7));
        default: mem_exc_flags_i = '0;
      endcase
      mem_pc_i        = $urandom;
      mem_data_addr_i = $urandom;
      epc_i           = $urandom;
      status_i        = {16'd0, 8'($urandom), 6'd0, 2'($urandom)};
      cause_i         = {22'd0, 2'($urandom), 8'd0};
      bus.redirect_ready_i = 1'($urandom_range(0, 1));
      settle();
      m_int    = status_i[0] && !status_i[1] && ((cause_i[9:8] & status_i[9:8]) != 2'b00);
      e_commit = !m_redir && mem_valid_i && !mem_stall_i && (m_int || mem_exc_flags_i != 0);
      e_type   = ref_type(m_int, mem_exc_flags_i);
      if (e_commit)
        exp = {e_type, mem_delayslot_i, mem_pc_i,
               (e_type == 4'd2) ? mem_pc_i : (e_type == 4'd3 || e_type == 4'd8) ? mem_data_addr_i : 32'd0,
               1'b1, 1'b0, 32'd0};
      else if (m_redir)
        exp = {4'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, m_rpc};
      else
        exp = '0;
      got = {bus.exc_type_o, bus.delayslot_o, bus.exc_pc_o, bus.badvaddr_o,
             bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random[%0d] got %h exp %h", n, got, exp);
      end
      if (e_commit) begin
        m_redir = 1;
        m_rpc   = (e_type == 4'd9) ? epc_i : VEC;
      end else if (m_redir && bus.redirect_ready_i) begin
        m_redir = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ov();
    test_prio();
    test_eret();
    test_int();
    test_timer();
    test_stall_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
